alu_logic_iter: RTL and testbench

Parametrised, multi-cycle bitwise logic unit for the ALU. It generalises the fixed 8-bit AND path to WIDTH-bit operands, eight logic operations and a ZERO/PARITY flag pair. Operands are processed CHUNK bits per cycle behind a valid/ready handshake, so wide datapaths do not need a full-width combinational path. The block sits in the ALU beside the arithmetic units and is driven by the control unit.

---
 rtl/alu_logic_iter.sv | 129 ++++++++++++
 tb/tb_alu_logic_iter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_logic_iter.sv
// rtl/alu_logic_iter.sv - multi-cycle WIDTH-bit logic unit, CHUNK bits per cycle
// Eight bitwise ops with ZERO/PARITY flags behind a valid/ready handshake.
module alu_logic_iter #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("alu_logic_iter: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       sel_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nxt;
  logic             last_chunk;

  function automatic logic [CHUNK-1:0] logic_op(input logic [2:0] sel,
                                               input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b);
    case (sel)
      3'b000:  logic_op = a & b;
      3'b001:  logic_op = a | b;
      3'b010:  logic_op = a ^ b;
      3'b011:  logic_op = ~(a & b);
      3'b100:  logic_op = ~(a | b);
      3'b101:  logic_op = ~(a ^ b);
      3'b110:  logic_op = a & ~b;
      default: logic_op = b;
    endcase
  endfunction

  assign last_chunk = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)   state_nxt = S_BUSY;
      S_BUSY:  if (last_chunk) state_nxt = S_DONE;
      S_DONE:  if (out_ready)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state == S_BUSY);
    out_valid = (state == S_DONE);
  end

  // Only the chunk selected by the counter is recomputed; the rest of shadow holds.
  always_comb begin
    shadow_nxt = shadow;
    for (int k = 0; k < N; k++) begin
      if (cnt == CW'(k)) begin
        shadow_nxt[k*CHUNK +: CHUNK] = logic_op(sel_q, a_q[k*CHUNK +: CHUNK],
                                                b_q[k*CHUNK +: CHUNK]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= '0;
      cnt    <= '0;
      shadow <= '0;
      result <= '0;
      zero   <= 1'b0;
      parity <= 1'b0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        a_q   <= data1;
        b_q   <= data2;
        sel_q <= select;
        cnt   <= '0;
      end
      if (state == S_BUSY) begin
        shadow <= shadow_nxt;
        if (last_chunk) begin
          result <= shadow_nxt;
          zero   <= ~|shadow_nxt;
          parity <= ^shadow_nxt;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_logic_iter.sv
// tb/tb_alu_logic_iter.sv - directed vector bench for alu_logic_iter
// Three instances (8/2, 8/8, 32/4) share stimulus so latencies are checked together.
module tb_alu_logic_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [2:0]  select = '0;

  logic       in_ready0, out_valid0, zero0, parity0, busy0;
  logic [7:0] result0;
  logic       in_ready1, out_valid1, zero1, parity1, busy1;
  logic [7:0] result1;
  logic        in_ready2, out_valid2, zero2, parity2, busy2;
  logic [31:0] result2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_logic_iter #(.WIDTH(8), .CHUNK(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .data1(data1[7:0]), .data2(data2[7:0]), .select(select),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
    .zero(zero0), .parity(parity0), .busy(busy0)
  );

  alu_logic_iter #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .data1(data1[7:0]), .data2(data2[7:0]), .select(select),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .zero(zero1), .parity(parity1), .busy(busy1)
  );

  alu_logic_iter #(.WIDTH(32), .CHUNK(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .data1(data1), .data2(data2), .select(select),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
    .zero(zero2), .parity(parity2), .busy(busy2)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  e8;
    logic        z8;
    logic        p8;
    logic        chk32;
    logic [31:0] e32;
    logic        p32;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for all three instances to complete and records each one's latency.
  task automatic wait_done(output int l0, output int l1, output int l2);
    l0 = -1; l1 = -1; l2 = -1;
    for (int c = 0; c < 30; c++) begin
      if (out_valid0 && l0 < 0) l0 = c;
      if (out_valid1 && l1 < 0) l1 = c;
      if (out_valid2 && l2 < 0) l2 = c;
      if (out_valid0 && out_valid1 && out_valid2) break;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_consume", {31'd0, in_ready0}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int l0, l1, l2;
    @(negedge clk);
    data1 = v.a; data2 = v.b; select = v.sel; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy0}, 32'd1);
    wait_done(l0, l1, l2);
    check("latency_w8c2", l0, 32'd4);
    check("latency_w8c8", l1, 32'd1);
    check("latency_w32c4", l2, 32'd8);
    check("result_w8c2", {24'd0, result0}, {24'd0, v.e8});
    check("zero_w8c2", {31'd0, zero0}, {31'd0, v.z8});
    check("parity_w8c2", {31'd0, parity0}, {31'd0, v.p8});
    check("result_w8c8", {24'd0, result1}, {24'd0, v.e8});
    if (v.chk32) begin
      check("result_w32c4", result2, v.e32);
      check("parity_w32c4", {31'd0, parity2}, {31'd0, v.p32});
    end
    consume();
  endtask

  initial begin
    logic [7:0] held;
    int l0, l1, l2;

    //           sel     a             b             e8     z8    p8    chk32 e32            p32
    tbl[0]  = '{3'b000, 32'h0000_00F0, 32'h0000_003C, 8'h30, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[1]  = '{3'b000, 32'h0000_00A5, 32'h0000_000F, 8'h05, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[2]  = '{3'b001, 32'h0000_00A5, 32'h0000_000F, 8'hAF, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[3]  = '{3'b010, 32'h0000_00A5, 32'h0000_000F, 8'hAA, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[4]  = '{3'b011, 32'h0000_00A5, 32'h0000_000F, 8'hFA, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[5]  = '{3'b100, 32'h0000_00A5, 32'h0000_000F, 8'h50, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[6]  = '{3'b101, 32'h0000_00A5, 32'h0000_000F, 8'h55, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[7]  = '{3'b110, 32'h0000_00A5, 32'h0000_000F, 8'hA0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[8]  = '{3'b111, 32'h0000_00A5, 32'h0000_000F, 8'h0F, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[9]  = '{3'b010, 32'h0000_00AA, 32'h0000_00AA, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[10] = '{3'b000, 32'h0000_0007, 32'h0000_00FF, 8'h07, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0};
    tbl[11] = '{3'b011, 32'h0000_00FF, 32'h0000_00FF, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[12] = '{3'b001, 32'h8000_0001, 32'h0000_FF00, 8'h01, 1'b0, 1'b1, 1'b1, 32'h8000_FF01, 1'b0};
    tbl[13] = '{3'b111, 32'h0000_0012, 32'h0000_0080, 8'h80, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0};

    #2;
    check("reset_in_ready", {31'd0, in_ready0}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid0}, 32'd0);
    check("reset_busy", {31'd0, busy0}, 32'd0);
    check("reset_result", {24'd0, result0}, 32'd0);
    check("reset_zero", {31'd0, zero0}, 32'd0);
    check("reset_parity", {31'd0, parity0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(tbl[i]);

    // Backpressure: stall 6 cycles with a new request pending.
    @(negedge clk);
    data1 = 32'h0000_00C3; data2 = 32'h0000_0055; select = 3'b010; in_valid = 1'b1;
    @(negedge clk);
    data1 = 32'h0000_00F0; data2 = 32'h0000_00FF; select = 3'b000;
    wait_done(l0, l1, l2);
    held = result0;
    check("bp_first_result", {24'd0, result0}, 32'h0000_0096);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_result_hold", {24'd0, result0}, 32'h0000_0096);
      check("bp_parity_hold", {31'd0, parity0}, 32'd0);
      check("bp_zero_hold", {31'd0, zero0}, 32'd0);
      check("bp_in_ready_low", {31'd0, in_ready0}, 32'd0);
      check("bp_out_valid_high", {31'd0, out_valid0}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_after_ec", {30'd0, busy0, in_ready0}, 32'd1);
    check("bp_result_after_ec", {24'd0, result0}, {24'd0, held});
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept_at_ec_plus1", {31'd0, busy0}, 32'd1);
    wait_done(l0, l1, l2);
    check("bp_second_result", {24'd0, result0}, 32'h0000_00F0);
    check("bp_second_parity", {31'd0, parity0}, 32'd0);
    consume();

    // Operand isolation: inputs churn during BUSY.
    @(negedge clk);
    data1 = 32'h0000_00A5; data2 = 32'h0000_000F; select = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      data1 = 32'($urandom_range(0, 255));
      select = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_done(l0, l1, l2);
    check("isolation_result", {24'd0, result0}, 32'h0000_0005);
    consume();

    // Reset during the second BUSY cycle.
    @(negedge clk);
    data1 = 32'h0000_00F0; data2 = 32'h0000_000F; select = 3'b001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check("rst_result", {24'd0, result0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_no_out_valid", {31'd0, out_valid0}, 32'd0);
    end
    @(negedge clk);
    data1 = 32'h0; data2 = 32'h0; select = 3'b100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(l0, l1, l2);
    check("post_rst_latency", l0, 32'd4);
    check("post_rst_result", {24'd0, result0}, 32'h0000_00FF);
    check("post_rst_zero", {31'd0, zero0}, 32'd0);
    check("post_rst_parity", {31'd0, parity0}, 32'd0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
